// File: rtl/sky130_sram_1rw1r_param.sv
`default_nettype none
// ============================================================================
//  Module   : sky130_sram_1rw1r_param
//  Purpose  : Parametrised 1RW + 1R SRAM model with one clock. Port 0 reads
//             and writes with per-lane write masks and per-bit spare-column
//             enables. Port 1 is read-only. Both ports return data after
//             READ_LATENCY edges, qualified by a one-cycle valid strobe.
//             Port 1 also reports a collision when it reads the address
//             that port 0 writes on the same edge. In that case the read
//             returns the old word.
//  Ports    : clk0        - single clock, rising edge
//             rst0        - asynchronous active-high reset of port logic
//             csb0/web0   - port 0 chip select / write enable (active low)
//             wmask0      - per-lane write enable (1 = write lane)
//             spare_wen0  - per-spare-bit write enable
//             addr0/din0  - port 0 address / write data
//             dout0       - port 0 read data, held until the next port 0 read
//             dout0_valid - strobe, dout0 carries new read data
//             csb1/addr1  - port 1 chip select (active low) / address
//             dout1       - port 1 read data, held until the next port 1 read
//             dout1_valid - strobe for dout1
//             collision   - strobe with dout1_valid; that read hit the
//                           port 0 write address of the same edge
//  Revision : 1.0  initial release
// ============================================================================
module sky130_sram_1rw1r_param #(
  parameter int WORD_SIZE      = 64,
  parameter int NUM_WMASKS     = 8,
  parameter int NUM_SPARE_COLS = 1,
  parameter int ADDR_WIDTH     = 10,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY   = 1,
  parameter int VERBOSE        = 1,
  parameter int DATA_WIDTH     = WORD_SIZE + NUM_SPARE_COLS
) (
  input  logic                      clk0,
  input  logic                      rst0,
  input  logic                      csb0,
  input  logic                      web0,
  input  logic [NUM_WMASKS-1:0]     wmask0,
  input  logic [NUM_SPARE_COLS-1:0] spare_wen0,
  input  logic [ADDR_WIDTH-1:0]     addr0,
  input  logic [DATA_WIDTH-1:0]     din0,
  output logic [DATA_WIDTH-1:0]     dout0,
  output logic                      dout0_valid,
  input  logic                      csb1,
  input  logic [ADDR_WIDTH-1:0]     addr1,
  output logic [DATA_WIDTH-1:0]     dout1,
  output logic                      dout1_valid,
  output logic                      collision
);

  localparam int LANE_W = WORD_SIZE / NUM_WMASKS;
  // One bit wider than the address so that a full 2^ADDR_WIDTH depth fits.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (WORD_SIZE % NUM_WMASKS != 0) begin : g_chk_wmask
      $error("sky130_sram_1rw1r_param: WORD_SIZE must be a multiple of NUM_WMASKS");
    end
    if (RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_chk_depth
      $error("sky130_sram_1rw1r_param: RAM_DEPTH exceeds 2^ADDR_WIDTH");
    end
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_chk_latency
      $error("sky130_sram_1rw1r_param: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Access decode
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic                  w_wr0;
  logic                  w_rd0;
  logic                  w_rd1;
  logic                  w_addr0_ok;
  logic                  w_addr1_ok;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_rd0_word;
  logic [DATA_WIDTH-1:0] w_rd1_word;

  always_comb begin
    w_wr0      = ~csb0 & ~web0;
    w_rd0      = ~csb0 &  web0;
    w_rd1      = ~csb1;
    w_addr0_ok = ({1'b0, addr0} < DEPTH_LIMIT);
    w_addr1_ok = ({1'b0, addr1} < DEPTH_LIMIT);
    // A zero-mask write is still a write cycle, so it still flags a collision.
    w_collide  = w_wr0 & w_rd1 & (addr0 == addr1);
    // The array is sampled before the edge, which gives read-before-write
    // on a same-address collision. Out-of-range reads return zero.
    w_rd0_word = w_addr0_ok ? mem_q[addr0] : '0;
    w_rd1_word = w_addr1_ok ? mem_q[addr1] : '0;
  end

  // --------------------------------------------------------------------------
  // Array write. Reset only suppresses writes; the contents are retained.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      // array intentionally not cleared
    end else if (w_wr0 && w_addr0_ok) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          mem_q[addr0][i*LANE_W +: LANE_W] <= din0[i*LANE_W +: LANE_W];
        end
      end
      for (int j = 0; j < NUM_SPARE_COLS; j++) begin
        if (spare_wen0[j]) begin
          mem_q[addr0][WORD_SIZE+j] <= din0[WORD_SIZE+j];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read stage 1: capture on the read edge. The data registers load only
  // on a read, so they double as the output hold registers when
  // READ_LATENCY is 1.
  // --------------------------------------------------------------------------
  logic                  rd0_s1_vld_q,  rd0_s1_vld_d;
  logic [DATA_WIDTH-1:0] rd0_s1_data_q, rd0_s1_data_d;
  logic                  rd1_s1_vld_q,  rd1_s1_vld_d;
  logic [DATA_WIDTH-1:0] rd1_s1_data_q, rd1_s1_data_d;
  logic                  col_s1_q,      col_s1_d;

  always_comb begin
    rd0_s1_vld_d  = w_rd0;
    rd0_s1_data_d = w_rd0 ? w_rd0_word : rd0_s1_data_q;
    rd1_s1_vld_d  = w_rd1;
    rd1_s1_data_d = w_rd1 ? w_rd1_word : rd1_s1_data_q;
    col_s1_d      = w_collide;
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      rd0_s1_vld_q  <= 1'b0;
      rd0_s1_data_q <= '0;
      rd1_s1_vld_q  <= 1'b0;
      rd1_s1_data_q <= '0;
      col_s1_q      <= 1'b0;
    end else begin
      rd0_s1_vld_q  <= rd0_s1_vld_d;
      rd0_s1_data_q <= rd0_s1_data_d;
      rd1_s1_vld_q  <= rd1_s1_vld_d;
      rd1_s1_data_q <= rd1_s1_data_d;
      col_s1_q      <= col_s1_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional stage 2: data, valid and collision move together, one edge later
  // --------------------------------------------------------------------------
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  rd0_s2_vld_q,  rd0_s2_vld_d;
      logic [DATA_WIDTH-1:0] rd0_s2_data_q, rd0_s2_data_d;
      logic                  rd1_s2_vld_q,  rd1_s2_vld_d;
      logic [DATA_WIDTH-1:0] rd1_s2_data_q, rd1_s2_data_d;
      logic                  col_s2_q,      col_s2_d;

      always_comb begin
        rd0_s2_vld_d  = rd0_s1_vld_q;
        rd0_s2_data_d = rd0_s1_vld_q ? rd0_s1_data_q : rd0_s2_data_q;
        rd1_s2_vld_d  = rd1_s1_vld_q;
        rd1_s2_data_d = rd1_s1_vld_q ? rd1_s1_data_q : rd1_s2_data_q;
        col_s2_d      = col_s1_q;
      end

      always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
          rd0_s2_vld_q  <= 1'b0;
          rd0_s2_data_q <= '0;
          rd1_s2_vld_q  <= 1'b0;
          rd1_s2_data_q <= '0;
          col_s2_q      <= 1'b0;
        end else begin
          rd0_s2_vld_q  <= rd0_s2_vld_d;
          rd0_s2_data_q <= rd0_s2_data_d;
          rd1_s2_vld_q  <= rd1_s2_vld_d;
          rd1_s2_data_q <= rd1_s2_data_d;
          col_s2_q      <= col_s2_d;
        end
      end

      assign dout0       = rd0_s2_data_q;
      assign dout0_valid = rd0_s2_vld_q;
      assign dout1       = rd1_s2_data_q;
      assign dout1_valid = rd1_s2_vld_q;
      assign collision   = col_s2_q;
    end else begin : g_lat1
      assign dout0       = rd0_s1_data_q;
      assign dout0_valid = rd0_s1_vld_q;
      assign dout1       = rd1_s1_data_q;
      assign dout1_valid = rd1_s1_vld_q;
      assign collision   = col_s1_q;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Simulation messages: out-of-range writes always warn; VERBOSE also
  // logs every access.
  // --------------------------------------------------------------------------
`ifndef SYNTHESIS
  always @(posedge clk0 or posedge rst0) begin
    if (!rst0) begin
      if (w_wr0 && !w_addr0_ok) begin
        $display("WARNING: %m port0 write to out-of-range address %0d dropped", addr0);
      end
      if (VERBOSE != 0) begin
        if (w_wr0 && w_addr0_ok) begin
          $display("%m: port0 write addr=%0d din=%h wmask=%b spare_wen=%b",
                   addr0, din0, wmask0, spare_wen0);
        end
        if (w_rd0) begin
          $display("%m: port0 read  addr=%0d", addr0);
        end
        if (w_rd1) begin
          $display("%m: port1 read  addr=%0d", addr1);
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sky130_sram_1rw1r_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sky130_sram_1rw1r_param
//  Purpose  : Directed self-checking bench for sky130_sram_1rw1r_param.
//             Two instances share all inputs: u_dut_l1 uses READ_LATENCY=1
//             and full depth, and u_dut_l2 uses READ_LATENCY=2 with
//             RAM_DEPTH=1000.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sky130_sram_1rw1r_param;

  logic        clk0       = 1'b0;
  logic        rst0       = 1'b0;
  logic        csb0       = 1'b1;
  logic        web0       = 1'b1;
  logic        csb1       = 1'b1;
  logic [7:0]  wmask0     = '0;
  logic [0:0]  spare_wen0 = '0;
  logic [9:0]  addr0      = '0;
  logic [9:0]  addr1      = '0;
  logic [64:0] din0       = '0;

  logic [64:0] dout0_a, dout1_a, dout0_b, dout1_b;
  logic        dout0_valid_a, dout1_valid_a, collision_a;
  logic        dout0_valid_b, dout1_valid_b, collision_b;

  int checks = 0;
  int errors = 0;

  always #5 clk0 = ~clk0;

  sky130_sram_1rw1r_param #(.READ_LATENCY(1), .VERBOSE(0)) u_dut_l1 (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .spare_wen0(spare_wen0), .addr0(addr0), .din0(din0), .dout0(dout0_a),
    .dout0_valid(dout0_valid_a), .csb1(csb1), .addr1(addr1), .dout1(dout1_a),
    .dout1_valid(dout1_valid_a), .collision(collision_a)
  );

  sky130_sram_1rw1r_param #(.READ_LATENCY(2), .RAM_DEPTH(1000), .VERBOSE(0)) u_dut_l2 (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .spare_wen0(spare_wen0), .addr0(addr0), .din0(din0), .dout0(dout0_b),
    .dout0_valid(dout0_valid_b), .csb1(csb1), .addr1(addr1), .dout1(dout1_b),
    .dout1_valid(dout1_valid_b), .collision(collision_b)
  );

  // Preload pattern for addresses 0..7 (spare bit = address LSB)
  function automatic logic [64:0] pat(input int idx);
    logic [64:0] v;
    v[64]   = idx[0];
    v[63:0] = 64'hC0DE_0000_0000_0000 | (64'(idx) * 64'h0001_0001);
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk0);
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = '0; spare_wen0 = '0;
  endtask

  task automatic write_word(input logic [9:0] wa, input logic [64:0] wd,
                            input logic [7:0] wm, input logic [0:0] ws);
    csb0 = 1'b0; web0 = 1'b0; addr0 = wa; din0 = wd; wmask0 = wm; spare_wen0 = ws;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    idle();
    #8 rst0 = 1'b1;
    #1;
    checks++;
    if ({dout0_a, dout1_a, dout0_valid_a, dout1_valid_a, collision_a} !== '0) begin
      errors++;
      $display("FAIL reset_async_l1: got %h/%h v0=%b v1=%b col=%b, required all zero",
               dout0_a, dout1_a, dout0_valid_a, dout1_valid_a, collision_a);
    end
    checks++;
    if ({dout0_b, dout1_b, dout0_valid_b, dout1_valid_b, collision_b} !== '0) begin
      errors++;
      $display("FAIL reset_async_l2: got %h/%h v0=%b v1=%b col=%b, required all zero",
               dout0_b, dout1_b, dout0_valid_b, dout1_valid_b, collision_b);
    end
    cycle();
    rst0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if ({dout0_a, dout1_a, dout0_b, dout1_b, dout0_valid_a, dout1_valid_a, collision_a,
           dout0_valid_b, dout1_valid_b, collision_b} !== '0) begin
        errors++;
        $display("FAIL reset_idle edge %0d: outputs not all zero (v0a=%b v1a=%b v0b=%b v1b=%b)",
                 k, dout0_valid_a, dout1_valid_a, dout0_valid_b, dout1_valid_b);
      end
    end
  endtask

  task automatic test_masked_write();
    logic [64:0] exp;
    exp = {1'b0, 64'hFFFF_FFFF_89AB_CDEF};
    write_word(10'd5, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 8'hFF, 1'b1);
    write_word(10'd5, {1'b1, 64'h0123_4567_89AB_CDEF}, 8'h0F, 1'b0);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 10'd5;
    cycle();
    idle();
    checks++;
    if (dout0_valid_a !== 1'b1 || dout0_a !== exp) begin
      errors++;
      $display("FAIL mask_rd_l1: valid=%b data=%h, required valid=1 data=%h", dout0_valid_a, dout0_a, exp);
    end
    checks++;
    if (dout0_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL mask_rd_l2_early: valid=%b, required 0", dout0_valid_b);
    end
    cycle();
    checks++;
    if (dout0_valid_a !== 1'b0 || dout0_a !== exp) begin
      errors++;
      $display("FAIL mask_hold_l1: valid=%b data=%h, required valid=0 data=%h", dout0_valid_a, dout0_a, exp);
    end
    checks++;
    if (dout0_valid_b !== 1'b1 || dout0_b !== exp) begin
      errors++;
      $display("FAIL mask_rd_l2: valid=%b data=%h, required valid=1 data=%h", dout0_valid_b, dout0_b, exp);
    end
    cycle();
    checks++;
    if (dout0_valid_b !== 1'b0 || dout0_b !== exp) begin
      errors++;
      $display("FAIL mask_hold_l2: valid=%b data=%h, required valid=0 data=%h", dout0_valid_b, dout0_b, exp);
    end
  endtask

  task automatic test_pipelined();
    for (int i = 0; i < 8; i++) write_word(i[9:0], pat(i), 8'hFF, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        csb1 = 1'b0; addr1 = k[9:0];
      end else begin
        csb1 = 1'b1;
      end
      cycle();
      checks++;
      if (dout1_valid_a !== (k < 8) || ((k < 8) && dout1_a !== pat(k))) begin
        errors++;
        $display("FAIL pipe_l1 edge %0d: valid=%b data=%h, required valid=%b data=%h",
                 k, dout1_valid_a, dout1_a, (k < 8), pat(k));
      end
      checks++;
      if (dout1_valid_b !== (k >= 1 && k <= 8) || ((k >= 1 && k <= 8) && dout1_b !== pat(k - 1))) begin
        errors++;
        $display("FAIL pipe_l2 edge %0d: valid=%b data=%h, required valid=%b data=%h",
                 k, dout1_valid_b, dout1_b, (k >= 1 && k <= 8), pat(k - 1));
      end
    end
    idle();
  endtask

  task automatic test_collision();
    write_word(10'd9, 65'h11, 8'hFF, 1'b1);
    csb0 = 1'b0; web0 = 1'b0; addr0 = 10'd9; din0 = 65'h22; wmask0 = 8'hFF; spare_wen0 = 1'b1;
    csb1 = 1'b0; addr1 = 10'd9;
    cycle();
    checks++;
    if (dout1_valid_a !== 1'b1 || collision_a !== 1'b1 || dout1_a !== 65'h11) begin
      errors++;
      $display("FAIL coll_l1: v=%b col=%b data=%h, required v=1 col=1 data=11", dout1_valid_a, collision_a, dout1_a);
    end
    checks++;
    if (dout1_valid_b !== 1'b0 || collision_b !== 1'b0) begin
      errors++;
      $display("FAIL coll_l2_early: v=%b col=%b, required 0 0", dout1_valid_b, collision_b);
    end
    csb0 = 1'b1; web0 = 1'b1;
    cycle();
    checks++;
    if (dout1_valid_a !== 1'b1 || collision_a !== 1'b0 || dout1_a !== 65'h22) begin
      errors++;
      $display("FAIL coll_reread_l1: v=%b col=%b data=%h, required v=1 col=0 data=22", dout1_valid_a, collision_a, dout1_a);
    end
    checks++;
    if (dout1_valid_b !== 1'b1 || collision_b !== 1'b1 || dout1_b !== 65'h11) begin
      errors++;
      $display("FAIL coll_l2: v=%b col=%b data=%h, required v=1 col=1 data=11", dout1_valid_b, collision_b, dout1_b);
    end
    idle();
    cycle();
    checks++;
    if (dout1_valid_a !== 1'b0 || collision_a !== 1'b0 || dout1_a !== 65'h22) begin
      errors++;
      $display("FAIL coll_hold_l1: v=%b col=%b data=%h, required v=0 col=0 data=22", dout1_valid_a, collision_a, dout1_a);
    end
    checks++;
    if (dout1_valid_b !== 1'b1 || collision_b !== 1'b0 || dout1_b !== 65'h22) begin
      errors++;
      $display("FAIL coll_reread_l2: v=%b col=%b data=%h, required v=1 col=0 data=22", dout1_valid_b, collision_b, dout1_b);
    end
    cycle();
  endtask

  task automatic test_reset_midflight();
    idle();
    csb0 = 1'b0; web0 = 1'b1; addr0 = 10'd0;
    cycle();
    idle();
    checks++;
    if (dout0_valid_a !== 1'b1 || dout0_a !== pat(0)) begin
      errors++;
      $display("FAIL midrst_l1_read: v=%b data=%h, required v=1 data=%h", dout0_valid_a, dout0_a, pat(0));
    end
    rst0 = 1'b1;
    #1;
    checks++;
    if (dout0_valid_b !== 1'b0 || dout0_b !== 65'h0) begin
      errors++;
      $display("FAIL midrst_async_l2: v=%b data=%h, required v=0 data=0", dout0_valid_b, dout0_b);
    end
    // Accesses presented during reset must be ignored, including writes.
    csb0 = 1'b0; web0 = 1'b0; addr0 = 10'd0; din0 = '0; wmask0 = 8'hFF; spare_wen0 = 1'b1;
    csb1 = 1'b0; addr1 = 10'd0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if ({dout0_valid_a, dout1_valid_a, dout0_valid_b, dout1_valid_b, collision_a, collision_b} !== 6'b0) begin
        errors++;
        $display("FAIL midrst_hold edge %0d: strobe seen during reset", k);
      end
    end
    idle();
    rst0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if ({dout0_valid_a, dout1_valid_a, dout0_valid_b, dout1_valid_b} !== 4'b0) begin
        errors++;
        $display("FAIL midrst_after edge %0d: v0b=%b, required no strobe", k, dout0_valid_b);
      end
    end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 10'd0;
    cycle();
    idle();
    checks++;
    if (dout0_valid_a !== 1'b1 || dout0_a !== pat(0)) begin
      errors++;
      $display("FAIL midrst_intact_l1: v=%b data=%h, required v=1 data=%h", dout0_valid_a, dout0_a, pat(0));
    end
    cycle();
    checks++;
    if (dout0_valid_b !== 1'b1 || dout0_b !== pat(0)) begin
      errors++;
      $display("FAIL midrst_intact_l2: v=%b data=%h, required v=1 data=%h", dout0_valid_b, dout0_b, pat(0));
    end
  endtask

  task automatic test_out_of_range();
    logic [64:0] ones;
    ones = '1;
    write_word(10'd9, 65'h0, 8'h00, 1'b0);   // zero-mask write leaves addr 9 alone
    write_word(10'd10, pat(10), 8'hFF, 1'b1);
    write_word(10'd1010, ones, 8'hFF, 1'b1);  // beyond depth of u_dut_l2 only
    csb0 = 1'b0; web0 = 1'b1; addr0 = 10'd1010; csb1 = 1'b0; addr1 = 10'd9;
    cycle();
    csb0 = 1'b1; addr1 = 10'd10;
    checks++;
    if (dout0_valid_a !== 1'b1 || dout0_a !== ones) begin
      errors++;
      $display("FAIL oor_l1_inrange: v=%b data=%h, required v=1 data=%h", dout0_valid_a, dout0_a, ones);
    end
    checks++;
    if (dout1_valid_a !== 1'b1 || dout1_a !== 65'h22) begin
      errors++;
      $display("FAIL zeromask_l1: v=%b data=%h, required v=1 data=22", dout1_valid_a, dout1_a);
    end
    cycle();
    idle();
    checks++;
    if (dout1_valid_a !== 1'b1 || dout1_a !== pat(10)) begin
      errors++;
      $display("FAIL oor_l1_addr10: v=%b data=%h, required v=1 data=%h", dout1_valid_a, dout1_a, pat(10));
    end
    checks++;
    if (dout0_valid_b !== 1'b1 || dout0_b !== 65'h0) begin
      errors++;
      $display("FAIL oor_l2_read: v=%b data=%h, required v=1 data=0", dout0_valid_b, dout0_b);
    end
    checks++;
    if (dout1_valid_b !== 1'b1 || dout1_b !== 65'h22) begin
      errors++;
      $display("FAIL zeromask_l2: v=%b data=%h, required v=1 data=22", dout1_valid_b, dout1_b);
    end
    cycle();
    checks++;
    if (dout1_valid_b !== 1'b1 || dout1_b !== pat(10)) begin
      errors++;
      $display("FAIL oor_l2_addr10: v=%b data=%h, required v=1 data=%h", dout1_valid_b, dout1_b, pat(10));
    end
    checks++;
    if (dout0_valid_b !== 1'b0 || dout0_b !== 65'h0) begin
      errors++;
      $display("FAIL oor_l2_hold: v=%b data=%h, required v=0 data=0", dout0_valid_b, dout0_b);
    end
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_pipelined();
    test_collision();
    test_reset_midflight();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
